// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame geometry and FSM state encoding.
package uart_pkg;

   // Payload width of one UART character.
   localparam int UART_DATA_BITS = 8;

   // Raw state codes, kept as named constants so other tools can decode the state register.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART transmitter. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = UART_DATA_BITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             empty
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   // A push while full is dropped here; the sender sees full and must hold its data.
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   assign empty    = (r_wr_ptr == r_rd_ptr);
   assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign data_out = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; push and pop on the same edge both take effect.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes from a valid/ready port and shifts them out
// LSB first as 8N1 or 8N2 frames. Back-to-back frames have no idle gap.
// txd is registered from the current state, so the line lags the FSM by one cycle.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       txd,
   output logic       busy
);

   // CLKS_PER_BIT must be at least 2 and STOP_BITS must be 1 or 2.
   localparam int               CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int               CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST    = 3'(STOP_BITS - 1);
   localparam logic [2:0]       DATA_LAST    = 3'(UART_DATA_BITS - 1);

   tx_state_t        r_state;
   tx_state_t        w_next_state;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [CNT_W-1:0] w_baud_cnt_next;
   logic [2:0]       r_bit_idx;
   logic [2:0]       w_bit_idx_next;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_next;
   logic             r_txd;
   logic             w_txd_next;
   logic             w_baud_wrap;
   logic             w_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [7:0]       w_fifo_head;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (UART_DATA_BITS)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (in_valid),
      .data_in  (in_data),
      .full     (w_fifo_full),
      .pop      (w_pop),
      .data_out (w_fifo_head),
      .empty    (w_fifo_empty)
   );

   assign w_baud_wrap = (r_baud_cnt == CNT_LAST);

   // Next-state, baud counter, bit index, shift register and FIFO pop decisions.
   always_comb begin
      w_next_state    = r_state;
      w_baud_cnt_next = w_baud_wrap ? '0 : r_baud_cnt + CNT_W'(1);
      w_bit_idx_next  = r_bit_idx;
      w_shift_next    = r_shift;
      w_pop           = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_baud_cnt_next = '0;
            if (!w_fifo_empty) begin
               w_pop        = 1'b1;
               w_shift_next = w_fifo_head;
               w_next_state = START;
            end
         end
         START: begin
            if (w_baud_wrap) begin
               w_next_state   = DATA;
               w_bit_idx_next = '0;
            end
         end
         DATA: begin
            if (w_baud_wrap) begin
               w_shift_next   = {1'b0, r_shift[7:1]};
               w_bit_idx_next = r_bit_idx + 3'd1;
               if (r_bit_idx == DATA_LAST) begin
                  w_next_state   = STOP;
                  w_bit_idx_next = '0;
               end
            end
         end
         STOP: begin
            // bit_idx counts stop bits here so 8N2 reuses the same register.
            if (w_baud_wrap) begin
               if (r_bit_idx == STOP_LAST) begin
                  w_bit_idx_next = '0;
                  if (!w_fifo_empty) begin
                     w_pop        = 1'b1;
                     w_shift_next = w_fifo_head;
                     w_next_state = START;
                  end else begin
                     w_next_state = IDLE;
                  end
               end else begin
                  w_bit_idx_next = r_bit_idx + 3'd1;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Line level for the current state; registered below to keep txd glitch-free.
   always_comb begin
      w_txd_next = 1'b1;
      unique case (r_state)
         IDLE:    w_txd_next = 1'b1;
         START:   w_txd_next = 1'b0;
         DATA:    w_txd_next = r_shift[0];
         STOP:    w_txd_next = 1'b1;
         default: w_txd_next = 1'b1;
      endcase
   end

   // Control state: reset aborts any frame in flight and parks the line high.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_txd      <= 1'b1;
      end else begin
         r_state    <= w_next_state;
         r_baud_cnt <= w_baud_cnt_next;
         r_bit_idx  <= w_bit_idx_next;
         r_txd      <= w_txd_next;
      end
   end

   // Shift register holds payload only; it is always reloaded before use.
   always_ff @(posedge clock) begin
      r_shift <= w_shift_next;
   end

   assign txd      = r_txd;
   assign in_ready = ~w_fifo_full;
   assign busy     = (r_state != IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/100ps
// Self-checking bench for uart_tx. A queue-and-timing reference model predicts
// txd, busy and in_ready every cycle for the 8N1 instance; a second 8N2 instance
// is checked against a directly computed frame.
module tb_uart_tx;

   localparam int CF     = 100;
   localparam int BR     = 10;
   localparam int CPB    = CF / BR;
   localparam int DEPTH  = 4;
   localparam int FRAME1 = (1 + 8 + 1) * CPB;

   typedef logic [7:0] byte_q_t[$];

   logic       clock    = 1'b0;
   logic       reset    = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_ready, txd, busy;
   logic       in_valid2 = 1'b0;
   logic [7:0] in_data2  = 8'h00;
   logic       in_ready2, txd2, busy2;

   always #1 clock = ~clock;

   uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .txd(txd), .busy(busy));

   uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
      .clock(clock), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
      .in_ready(in_ready2), .txd(txd2), .busy(busy2));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: pending bytes, edge index, and when the line frees up.
   byte_q_t    m_q;
   int         k         = 0;
   int         free_edge = 0;
   int         cur_p     = 0;
   logic [7:0] cur_b     = 8'h00;
   bit         cur_valid = 0;
   bit         m_acc     = 0;
   logic       m_txd = 1'b1, m_busy = 1'b0, m_ready = 1'b1;

   // Line level in bit slot 'slot' of a frame: start, 8 data LSB first, then stop level.
   function automatic logic frame_bit(input logic [7:0] b, input int slot);
      if (slot == 0)      return 1'b0;
      else if (slot <= 8) return b[slot-1];
      else                return 1'b1;
   endfunction

   task automatic model_reset();
      m_q.delete();
      cur_valid = 0;
      free_edge = 0;
      m_acc     = 0;
      m_txd     = 1'b1;
      m_busy    = 1'b0;
      m_ready   = 1'b1;
   endtask

   // One clock edge of the model. A byte is taken for transmission on the first
   // edge where something is queued and the previous frame's time has elapsed;
   // the line shows that frame starting one edge later.
   task automatic model_edge();
      int pre;
      k++;
      pre   = m_q.size();
      m_acc = in_valid && (pre < DEPTH);
      if (pre > 0 && k >= free_edge) begin
         cur_b     = m_q.pop_front();
         cur_p     = k;
         cur_valid = 1;
         free_edge = k + FRAME1;
      end
      if (m_acc) m_q.push_back(in_data);
      m_ready = (m_q.size() < DEPTH);
      m_busy  = (m_q.size() > 0) || (k < free_edge);
      m_txd   = 1'b1;
      if (cur_valid && k > cur_p && k <= cur_p + FRAME1)
         m_txd = frame_bit(cur_b, (k - cur_p - 1) / CPB);
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check("txd", txd, m_txd);
      check("busy", busy, m_busy);
      check("in_ready", in_ready, m_ready);
   endtask

   // Offer each byte with in_valid held until accepted, then an optional gap.
   task automatic send(input byte_q_t bs, input int gap_max);
      int guard;
      foreach (bs[i]) begin
         in_valid = 1'b1;
         in_data  = bs[i];
         guard    = 0;
         do begin
            tick();
            guard++;
         end while (!m_acc && guard < 2000);
         if (!m_acc) check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      end
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (m_busy && guard < 5000) begin
         tick();
         guard++;
      end
      repeat (3) tick();
   endtask

   initial begin
      byte_q_t bs;
      logic    exp2;
      model_reset();
      #0.2 reset = 1'b0;
      #1.3;
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clock);
      reset = 1'b1;
      repeat (3) tick();

      // Single byte 0x55.
      bs = {8'h55};
      send(bs, 0);
      wait_idle();

      // Back-to-back 0x00 then 0xFF on consecutive edges.
      bs = {8'h00, 8'hFF};
      send(bs, 0);
      wait_idle();

      // Six bytes offered continuously: FIFO fills and in_ready drops.
      bs = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
      send(bs, 0);
      wait_idle();

      // Longer burst so refills land on the same edges as pops from a full FIFO.
      bs = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send(bs, 0);
      wait_idle();

      // Reset in the middle of a frame: outputs return to idle at once, no resume.
      bs = {8'h3C, 8'hC3};
      send(bs, 0);
      repeat (35) tick();
      #0.5 reset = 1'b0;
      #0.1;
      check("rst_mid_txd", txd, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_in_ready", in_ready, 1);
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      repeat (150) tick();

      // 8N2 instance: 0x80 gives a 110-cycle frame with 20 cycles of stop level.
      check("d2_ready_pre", in_ready2, 1);
      in_valid2 = 1'b1;
      in_data2  = 8'h80;
      tick();
      in_valid2 = 1'b0;
      check("d2_busy_acc", busy2, 1);
      for (int i = 1; i <= 125; i++) begin
         tick();
         exp2 = (i >= 2 && i < 112) ? frame_bit(8'h80, (i - 2) / CPB) : 1'b1;
         check("d2_txd", txd2, exp2);
         check("d2_busy", busy2, (i < 111) ? 1 : 0);
      end

      // Randomized bursts with random byte values and gaps.
      repeat (25) begin
         bs.delete();
         repeat ($urandom_range(1, 7)) bs.push_back(8'($urandom));
         send(bs, $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) wait_idle();
         else repeat ($urandom_range(0, 150)) tick();
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
